// File: rtl/game_pkg.sv
// game_pkg: shared types and default HID keycodes for the game control path.
//   key_action_t : one decoded control action (only one key is active at a time)
//   HID_*        : default USB HID keycodes for the keyboard bindings
package game_pkg;

  typedef enum logic [3:0] {
    ACT_NONE,
    ACT_P_UP,
    ACT_P_LEFT,
    ACT_P_RIGHT,
    ACT_P_SHOOT,
    ACT_N_UP,
    ACT_N_LEFT,
    ACT_N_RIGHT,
    ACT_N_SHOOT,
    ACT_FIGHT
  } key_action_t;

  localparam logic [7:0] HID_W     = 8'h1A;
  localparam logic [7:0] HID_A     = 8'h04;
  localparam logic [7:0] HID_D     = 8'h07;
  localparam logic [7:0] HID_SPACE = 8'h2C;
  localparam logic [7:0] HID_UP    = 8'h52;
  localparam logic [7:0] HID_LEFT  = 8'h50;
  localparam logic [7:0] HID_RIGHT = 8'h4F;
  localparam logic [7:0] HID_COMMA = 8'h36;
  localparam logic [7:0] HID_ENTER = 8'h28;

endpackage

// File: rtl/shot_limiter.sv
// shot_limiter: per-shooter rate limiter.
//   Clk, Reset : clock, synchronous active-high reset
//   tick       : one-cycle frame marker
//   enable     : gameplay enable; low holds the cooldown at 0 and blocks shots
//   press      : press event, qualified by tick
//   shoot      : registered single-cycle shot pulse
// The cooldown is tested before it is decremented, so with COOLDOWN = N
// repeated presses fire at frames f, f+N+1, ... A press during cooldown is
// dropped, never queued.
module shot_limiter #(
  parameter int COOLDOWN = 15
) (
  input  logic Clk,
  input  logic Reset,
  input  logic tick,
  input  logic enable,
  input  logic press,
  output logic shoot
);

  logic [7:0] cnt;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt   <= 8'd0;
      shoot <= 1'b0;
    end else begin
      shoot <= 1'b0;
      if (!enable) begin
        cnt <= 8'd0;
      end else if (tick) begin
        if (press && cnt == 8'd0) begin
          shoot <= 1'b1;
          cnt   <= COOLDOWN[7:0];
        end else if (cnt != 8'd0) begin
          cnt <= cnt - 8'd1;
        end
      end
    end
  end

endmodule

// File: rtl/keycode_decoder.sv
// keycode_decoder: turns the HID keycode from the keyboard driver into
// frame-aligned player / NPC / stage controls.
//   Clk, Reset           : system clock, synchronous active-high reset
//   frame_clk            : VGA vertical sync, asynchronous to Clk
//   enable               : gameplay enable
//   keycode              : current HID keycode, 8'h00 = no key
//   Player_*/NPC_* moves : held levels, updated once per frame
//   Player_Shoot/NPC_Shoot, Fight : single-cycle press pulses
//   frame_tick           : one-cycle marker per frame_clk rise
module keycode_decoder
  import game_pkg::*;
#(
  parameter int         SHOOT_COOLDOWN = 15,
  parameter logic [7:0] KEY_P_UP    = HID_W,
  parameter logic [7:0] KEY_P_LEFT  = HID_A,
  parameter logic [7:0] KEY_P_RIGHT = HID_D,
  parameter logic [7:0] KEY_P_SHOOT = HID_SPACE,
  parameter logic [7:0] KEY_N_UP    = HID_UP,
  parameter logic [7:0] KEY_N_LEFT  = HID_LEFT,
  parameter logic [7:0] KEY_N_RIGHT = HID_RIGHT,
  parameter logic [7:0] KEY_N_SHOOT = HID_COMMA,
  parameter logic [7:0] KEY_FIGHT   = HID_ENTER
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       enable,
  input  logic [7:0] keycode,
  output logic       Player_Up,
  output logic       Player_Left,
  output logic       Player_Right,
  output logic       NPC_Up,
  output logic       NPC_Left,
  output logic       NPC_Right,
  output logic       Player_Shoot,
  output logic       NPC_Shoot,
  output logic       Fight,
  output logic       frame_tick
);

  // [0],[1] synchronizer, [2] edge register
  logic [2:0]  fs_pipe;
  logic [1:0]  flush;
  logic        armed;
  logic        tick;
  logic [7:0]  kc_q;
  key_action_t dec, cur_key, prev_key, nxt_cur, nxt_prev;

  // Ticks are only accepted once the synchronized frame_clk has been seen
  // low after reset, so a frame_clk held high across reset cannot fake an edge.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      fs_pipe <= 3'b000;
      flush   <= 2'b00;
      armed   <= 1'b0;
      tick    <= 1'b0;
    end else begin
      fs_pipe <= {fs_pipe[1:0], frame_clk};
      flush   <= {flush[0], 1'b1};
      armed   <= armed | (flush[1] & ~fs_pipe[1]);
      tick    <= armed & fs_pipe[1] & ~fs_pipe[2];
    end
  end

  assign frame_tick = tick;

  // Priority decode; unmatched codes (including 8'h00) mean no action.
  always_comb begin
    dec = ACT_NONE;
    if      (kc_q == 8'h00)       dec = ACT_NONE;
    else if (kc_q == KEY_P_UP)    dec = ACT_P_UP;
    else if (kc_q == KEY_P_LEFT)  dec = ACT_P_LEFT;
    else if (kc_q == KEY_P_RIGHT) dec = ACT_P_RIGHT;
    else if (kc_q == KEY_P_SHOOT) dec = ACT_P_SHOOT;
    else if (kc_q == KEY_N_UP)    dec = ACT_N_UP;
    else if (kc_q == KEY_N_LEFT)  dec = ACT_N_LEFT;
    else if (kc_q == KEY_N_RIGHT) dec = ACT_N_RIGHT;
    else if (kc_q == KEY_N_SHOOT) dec = ACT_N_SHOOT;
    else if (kc_q == KEY_FIGHT)   dec = ACT_FIGHT;
  end

  // Next-state view of the key history, so presses and levels land in the
  // cycle right after the tick.
  assign nxt_cur  = tick ? dec     : cur_key;
  assign nxt_prev = tick ? cur_key : prev_key;

  logic p_shoot_press, n_shoot_press, fight_press;
  assign p_shoot_press = (nxt_cur == ACT_P_SHOOT) && (nxt_prev != ACT_P_SHOOT);
  assign n_shoot_press = (nxt_cur == ACT_N_SHOOT) && (nxt_prev != ACT_N_SHOOT);
  assign fight_press   = (nxt_cur == ACT_FIGHT)   && (nxt_prev != ACT_FIGHT);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      kc_q         <= 8'h00;
      cur_key      <= ACT_NONE;
      prev_key     <= ACT_NONE;
      Player_Up    <= 1'b0;
      Player_Left  <= 1'b0;
      Player_Right <= 1'b0;
      NPC_Up       <= 1'b0;
      NPC_Left     <= 1'b0;
      NPC_Right    <= 1'b0;
      Fight        <= 1'b0;
    end else begin
      kc_q     <= keycode;
      cur_key  <= nxt_cur;
      prev_key <= nxt_prev;
      // Fight ignores enable: the start screen runs with enable low.
      Fight    <= tick & fight_press;
      if (tick) begin
        Player_Up    <= enable && (dec == ACT_P_UP);
        Player_Left  <= enable && (dec == ACT_P_LEFT);
        Player_Right <= enable && (dec == ACT_P_RIGHT);
        NPC_Up       <= enable && (dec == ACT_N_UP);
        NPC_Left     <= enable && (dec == ACT_N_LEFT);
        NPC_Right    <= enable && (dec == ACT_N_RIGHT);
      end else if (!enable) begin
        Player_Up    <= 1'b0;
        Player_Left  <= 1'b0;
        Player_Right <= 1'b0;
        NPC_Up       <= 1'b0;
        NPC_Left     <= 1'b0;
        NPC_Right    <= 1'b0;
      end
    end
  end

  shot_limiter #(.COOLDOWN(SHOOT_COOLDOWN)) u_p_shot (
    .Clk    (Clk),
    .Reset  (Reset),
    .tick   (tick),
    .enable (enable),
    .press  (p_shoot_press),
    .shoot  (Player_Shoot)
  );

  shot_limiter #(.COOLDOWN(SHOOT_COOLDOWN)) u_n_shot (
    .Clk    (Clk),
    .Reset  (Reset),
    .tick   (tick),
    .enable (enable),
    .press  (n_shoot_press),
    .shoot  (NPC_Shoot)
  );

endmodule

// File: doc/keycode_decoder.md
# keycode_decoder

Converts the 8-bit USB HID keycode exported by the Nios II keyboard driver into frame-aligned game controls for the player, the NPC and stage control. It replaces the switch and push-button control inputs in the top level. It sits between the keycode PIO output and the player, npc, projectile and stage_control blocks. All outputs update once per video frame, at the VGA vertical-sync rising edge. Press events are edge-detected and shots are rate-limited with a per-shooter cooldown.

## Interface
Parameters:
- SHOOT_COOLDOWN, default 15: frames that must pass after a shot before the same shooter can shoot again; legal range 0..255.
- KEY_P_UP / KEY_P_LEFT / KEY_P_RIGHT / KEY_P_SHOOT, defaults 8'h1A (W) / 8'h04 (A) / 8'h07 (D) / 8'h2C (Space).
- KEY_N_UP / KEY_N_LEFT / KEY_N_RIGHT / KEY_N_SHOOT, defaults 8'h52 / 8'h50 / 8'h4F (arrow keys) / 8'h36 (comma).
- KEY_FIGHT, default 8'h28 (Enter).

Ports:
- Clk, in, 1: system clock (CLOCK_50).
- Reset, in, 1: synchronous, active-high.
- frame_clk, in, 1: VGA_VS. Asynchronous to Clk.
- enable, in, 1: gameplay enable (battle_l).
- keycode, in, 8: current HID keycode; 8'h00 means no key.
- Player_Up, Player_Left, Player_Right, out, 1 each: held-level controls.
- NPC_Up, NPC_Left, NPC_Right, out, 1 each: held-level controls.
- Player_Shoot, NPC_Shoot, out, 1 each: single-cycle shot pulses.
- Fight, out, 1: single-cycle start pulse.
- frame_tick, out, 1: debug output; single-cycle pulse marking each frame.

## Operation
- frame_clk passes through a 2-flop synchronizer, then a rising-edge detector. The detector output is the internal tick, also driven on frame_tick.
- keycode is registered every Clk into kc_q and decoded against the key parameters. An unmatched code decodes to no action. Only one key can be active at a time.
- On each tick:
  - cur_key is loaded with the decoded action and prev_key is loaded with the old cur_key.
  - Held levels are set to (cur_key == that action) AND enable.
- A press means the action matches cur_key and does not match prev_key. Holding a key therefore produces exactly one press.
- Shoot, per shooter:
  - An 8-bit cooldown counter is checked before it is decremented.
  - If a press occurs, enable = 1 and the counter is 0: pulse the shoot output and load the counter with SHOOT_COOLDOWN.
  - Otherwise, if the counter is greater than 0: decrement it on the tick.
  - A press that arrives while the counter is non-zero is dropped, not queued.
- Fight: pulses on a KEY_FIGHT press and ignores enable, because the start screen has enable = 0.
- While enable = 0: all level outputs are 0, the shoot pulses are suppressed, and both cooldown counters are held at 0. prev_key and cur_key continue to track the keycode.
- Reset: all registers and outputs go to 0, including the synchronizer flops. A reset in mid-cooldown clears the counter.
- If the synchronizer flops are still high when reset releases, no tick is generated until the next rising edge of frame_clk.

## Timing
- Tick: asserted 3 Clk cycles after a frame_clk rise that meets setup (2 synchronizer flops plus the edge register). It is exactly 1 cycle wide.
- Level and pulse outputs are registered and change in the cycle after the tick. Pulses are exactly 1 Clk wide, and there is at most one pulse per output per frame.
- A keycode change reaches the outputs at the first tick at least 1 Clk after the change, because of the kc_q stage.
- If a keycode changes in the same cycle as a tick, the old value is used.
- With SHOOT_COOLDOWN = N, repeated presses get shots at frames f, f+N+1, f+2(N+1), and so on.
- N = 0 allows one shot per press with no extra frame limit.

## Structure
- Shared package game_pkg holds:
  - typedef enum key_action_t {ACT_NONE, ACT_P_UP, ACT_P_LEFT, ACT_P_RIGHT, ACT_P_SHOOT, ACT_N_UP, ACT_N_LEFT, ACT_N_RIGHT, ACT_N_SHOOT, ACT_FIGHT}.
  - The default HID keycode constants.
- Sub-module shot_limiter (press, tick, enable → shoot pulse, with an 8-bit counter) is instantiated once per shooter.
- The synchronizer and edge detector stay inline.
- Expected size: about 180 lines of RTL.

## Test plan
- Reset and idle: assert Reset, then release it, with keycode = 00 and frame_clk toggling → every output stays 0 and frame_tick pulses once per frame_clk rise, 3 cycles after the rise.
- Held move: keycode = 04 for 5 frames, enable = 1 → Player_Left rises the cycle after the first qualifying tick, stays high for 5 frames, then falls one frame after keycode = 00.
- Edge and cooldown: SHOOT_COOLDOWN = 3; Space pressed and released on alternate frames → Player_Shoot pulses at frames 0 and 4 only. Holding Space for 10 frames → exactly one pulse.
- enable gating: keycode = 50 and enable = 0 → NPC_Left = 0. Then keycode = 28 → Fight pulses once. Raising enable while 50 is held → NPC_Left goes high at the next tick.
- Reset mid-cooldown: Reset asserted 1 frame after an NPC_Shoot pulse, then a new comma press → NPC_Shoot pulses on the first tick after the press.
- Unknown and same-cycle change: keycode = 99 → no outputs change. keycode changed in the same cycle as a tick → the old action is applied this frame and the new one next frame.
